interconnect_link_merger: RTL and testbench
===========================================

Name: interconnect_link_merger

Overview:
- Receiving counterpart of the link splitter: merges the per-plane links of one interconnect link bundle back into a single local link.
- Used on the mesh-to-peripheral path, e.g. the response path into a memory or host adapter.
- A round-robin arbiter selects one requesting physical plane per cycle and pushes its packet into a small FIFO.
- The FIFO head drives the local link from registers.

Parameters:
- NUM_PLANES, default TIA_NUM_PHYSICAL_PLANES: number of physical planes in the bundle (≥1).
- BUFFER_DEPTH, default 2: output FIFO entries; power of two, ≥2.
- Tag width is TIA_TAG_WIDTH and word width is TIA_WORD_WIDTH, both taken from interconnect.svh.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- input_interconnect_link.reqs  input  NUM_PLANES  per-plane request (interconnect_link_if.receiver).
- input_interconnect_link.acks  output  NUM_PLANES  per-plane acknowledge.
- input_interconnect_link.tag_lines  input  NUM_PLANES x TIA_TAG_WIDTH  per-plane tag.
- input_interconnect_link.data_lines  input  NUM_PLANES x TIA_WORD_WIDTH  per-plane data.
- output_link.req  output  1  local link request (link_if.sender).
- output_link.ack  input  1  local link acknowledge.
- output_link.packet.tag  output  TIA_TAG_WIDTH  head tag.
- output_link.packet.data  output  TIA_WORD_WIDTH  head data.

Behaviour:
- Handshake:
  - A transfer occurs on any link in a cycle where req and ack are both high at the rising edge.
  - Senders hold req, tag and data stable until acked.
- Reset, synchronous:
  - FIFO count 0; read/write pointers 0; round-robin pointer rr_ptr 0.
  - output_link.req 0; packet outputs 0; all acks 0.
  - Reset asserted mid-operation discards buffered packets. No output req until the cycle after reset deasserts.
- Arbitration:
  - grant is the first plane i with reqs[i]=1, scanning from rr_ptr upward modulo NUM_PLANES.
  - grant_valid = |reqs.
- Acknowledge:
  - acks[grant]=1 iff grant_valid and count < BUFFER_DEPTH.
  - All other acks are 0, and at most one ack bit is high per cycle.
  - acks depend only on reqs and registered state. There is no combinational path from output_link.ack to acks.
- Push:
  - On an accepted input, tag/data of plane grant are written at the write pointer and the write pointer increments.
  - rr_ptr <= (grant+1) mod NUM_PLANES.
  - With no accept, rr_ptr holds.
- Pop:
  - output_link.req = (count != 0); packet equals the FIFO head, driven from registered storage.
  - On output_link.req && output_link.ack, the read pointer increments.
- Count:
  - Push only: +1. Pop only: −1. Simultaneous push and pop: unchanged, and both occur.
  - Full (count = BUFFER_DEPTH): all acks 0, even if a pop occurs in the same cycle.
  - Empty: output_link.req 0, and output_link.ack is ignored.
- Latency: a packet accepted at edge t into an empty FIFO appears with output_link.req=1 in cycle t+1.
- Throughput: one packet per cycle sustained when the downstream acks every cycle and BUFFER_DEPTH ≥2.
- Ordering:
  - Packets leave in acceptance order.
  - Per-plane order is preserved.
  - There is no cross-plane ordering beyond arbitration order.
- Pointer wrap: read/write pointers are log2(BUFFER_DEPTH) bits and wrap naturally. count is log2(BUFFER_DEPTH)+1 bits.
- NUM_PLANES=1: the arbiter degenerates to a pass-through grant; rr_ptr is constant 0.

Optional Feature:
- Macro: TIA_LINK_MERGER_FIXED_PRIORITY_EN.
- Defined: grant is the lowest-indexed requesting plane; rr_ptr is removed. A continuously requesting plane 0 may starve higher planes; this is intended for latency-critical plane 0 traffic.
- Undefined (default): round-robin as specified in Behaviour, with a starvation bound of NUM_PLANES−1 grants to other planes.

Test Plan:
- Single packet, NUM_PLANES=2, plane 1 req with tag=3, data=0xDEADBEEF, output ack held 1 -> acks=2'b10 in cycle 0; output req=1 with tag=3, data=0xDEADBEEF in cycle 1; req=0 in cycle 2.
- Fairness: both planes req continuously (plane0 data=0x10+n, plane1 data=0x20+n), output ack=1 -> outputs alternate 0x10, 0x20, 0x11, 0x21, ...; one output per cycle after the first.
- Backpressure: output ack=0, 4 packets offered on plane 0, BUFFER_DEPTH=2 -> exactly 2 acked, acks then stay 0. Releasing ack drains both in order; remaining packets then accepted.
- Full with simultaneous pop: FIFO full, output ack=1 for one cycle while plane 0 reqs -> pop occurs, no ack that cycle, plane 0 acked the next cycle; count goes 2→1→2.
- Reset mid-stream: 2 packets buffered, reset pulsed 1 cycle -> output req=0 and acks=0 the cycle after; buffered packets never emitted; next accepted packet appears with 1-cycle latency.
- With TIA_LINK_MERGER_FIXED_PRIORITY_EN defined, both planes req continuously -> only plane 0 acked while its req stays high; plane 1 acked the first cycle plane 0 drops req.

Source files
------------

// File: rtl/interconnect_link_merger_if.sv
// Link interfaces for interconnect_link_merger: the multi-plane interconnect bundle
// and the single local link. Widths come from TIA_* macros, with defaults if not predefined.
`ifndef TIA_TAG_WIDTH
`define TIA_TAG_WIDTH 4
`endif
`ifndef TIA_WORD_WIDTH
`define TIA_WORD_WIDTH 32
`endif
`ifndef TIA_NUM_PHYSICAL_PLANES
`define TIA_NUM_PHYSICAL_PLANES 2
`endif

interface interconnect_link_if #(
   parameter int NUM_PLANES = `TIA_NUM_PHYSICAL_PLANES
);
   logic [NUM_PLANES-1:0]                      reqs;
   logic [NUM_PLANES-1:0]                      acks;
   logic [NUM_PLANES-1:0][`TIA_TAG_WIDTH-1:0]  tag_lines;
   logic [NUM_PLANES-1:0][`TIA_WORD_WIDTH-1:0] data_lines;

   modport sender   (output reqs, output tag_lines, output data_lines, input  acks);
   modport receiver (input  reqs, input  tag_lines, input  data_lines, output acks);
endinterface

interface link_if;
   typedef struct packed {
      logic [`TIA_TAG_WIDTH-1:0]  tag;
      logic [`TIA_WORD_WIDTH-1:0] data;
   } packet_t;

   logic    req;
   logic    ack;
   packet_t packet;

   modport sender   (output req, output packet, input  ack);
   modport receiver (input  req, input  packet, output ack);
endinterface

// File: rtl/interconnect_link_merger.sv
// Merges the per-plane links of an interconnect bundle into one local link through a small FIFO.
// Optional macro TIA_LINK_MERGER_FIXED_PRIORITY_EN selects fixed priority instead of round-robin.
`ifndef TIA_TAG_WIDTH
`define TIA_TAG_WIDTH 4
`endif
`ifndef TIA_WORD_WIDTH
`define TIA_WORD_WIDTH 32
`endif
`ifndef TIA_NUM_PHYSICAL_PLANES
`define TIA_NUM_PHYSICAL_PLANES 2
`endif

module interconnect_link_merger #(
   parameter int NUM_PLANES   = `TIA_NUM_PHYSICAL_PLANES,
   parameter int BUFFER_DEPTH = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   interconnect_link_if.receiver input_interconnect_link,
   link_if.sender                output_link
);
   localparam int AW = $clog2(BUFFER_DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
   localparam int TW = `TIA_TAG_WIDTH;
   localparam int WW = `TIA_WORD_WIDTH;

   logic [TW-1:0]         tag_mem_q  [BUFFER_DEPTH];
   logic [WW-1:0]         data_mem_q [BUFFER_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [PW-1:0]         grant;
   logic                  grant_valid;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic [NUM_PLANES-1:0] acks;

   assign grant_valid = |input_interconnect_link.reqs;
   assign full        = (count_q == CW'(BUFFER_DEPTH));

`ifdef TIA_LINK_MERGER_FIXED_PRIORITY_EN
   always_comb begin
      grant = '0;
      for (int i = NUM_PLANES - 1; i >= 0; i--) begin
         if (input_interconnect_link.reqs[i]) grant = PW'(i);
      end
   end
`else
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;

   // Scan upward from rr_ptr, wrapping modulo NUM_PLANES; first requester wins.
   always_comb begin
      logic          found;
      logic [PW-1:0] idx;
      found = 1'b0;
      idx   = '0;
      grant = '0;
      for (int k = 0; k < NUM_PLANES; k++) begin
         if ((int'(rr_ptr_q) + k) >= NUM_PLANES) idx = PW'(int'(rr_ptr_q) + k - NUM_PLANES);
         else                                    idx = PW'(int'(rr_ptr_q) + k);
         if (!found && input_interconnect_link.reqs[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (push) begin
         if ((int'(grant) + 1) >= NUM_PLANES) rr_ptr_d = '0;
         else                                 rr_ptr_d = PW'(int'(grant) + 1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) rr_ptr_q <= '0;
      else       rr_ptr_q <= rr_ptr_d;
   end
`endif

   // Accept only with a free slot; a pop in the same cycle does not open one.
   assign push = grant_valid && !full && !reset;
   assign pop  = (count_q != '0) && output_link.ack;

   always_comb begin
      acks = '0;
      if (push) acks[grant] = 1'b1;
   end
   assign input_interconnect_link.acks = acks;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         tag_mem_q[wr_ptr_q]  <= input_interconnect_link.tag_lines[grant];
         data_mem_q[wr_ptr_q] <= input_interconnect_link.data_lines[grant];
      end
   end

   // Packet is forced to zero while empty so storage needs no reset.
   assign output_link.req         = (count_q != '0);
   assign output_link.packet.tag  = output_link.req ? tag_mem_q[rd_ptr_q]  : '0;
   assign output_link.packet.data = output_link.req ? data_mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_interconnect_link_merger.sv
// Self-checking bench for interconnect_link_merger: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
`ifndef TIA_TAG_WIDTH
`define TIA_TAG_WIDTH 4
`endif
`ifndef TIA_WORD_WIDTH
`define TIA_WORD_WIDTH 32
`endif
`ifndef TIA_NUM_PHYSICAL_PLANES
`define TIA_NUM_PHYSICAL_PLANES 2
`endif

module tb_interconnect_link_merger;
   localparam int NP    = 2;
   localparam int DEPTH = 2;
   localparam int TW    = `TIA_TAG_WIDTH;
   localparam int WW    = `TIA_WORD_WIDTH;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   interconnect_link_if #(.NUM_PLANES(NP)) in_if ();
   link_if out_if ();

   interconnect_link_merger #(.NUM_PLANES(NP), .BUFFER_DEPTH(DEPTH)) dut (
      .clock                   (clock),
      .reset                   (reset),
      .input_interconnect_link (in_if),
      .output_link             (out_if)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [NP-1:0] reqs, input logic [TW-1:0] t0, input logic [WW-1:0] d0,
                        input logic [TW-1:0] t1, input logic [WW-1:0] d1, input logic oack);
      in_if.reqs          = reqs;
      in_if.tag_lines[0]  = t0;
      in_if.data_lines[0] = d0;
      in_if.tag_lines[1]  = t1;
      in_if.data_lines[1] = d1;
      out_if.ack          = oack;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
   endtask

   typedef struct {
      logic [NP-1:0] reqs;
      logic [TW-1:0] t0;
      logic [WW-1:0] d0;
      logic [TW-1:0] t1;
      logic [WW-1:0] d1;
      logic          oack;
      logic [NP-1:0] eacks;
      logic          ereq;
      logic [TW-1:0] etag;
      logic [WW-1:0] edata;
   } vec_t;

   vec_t vt[$];

   function automatic int model_grant(input logic [NP-1:0] r, input int rr);
`ifdef TIA_LINK_MERGER_FIXED_PRIORITY_EN
      for (int i = 0; i < NP; i++) if (r[i]) return i;
`else
      for (int k = 0; k < NP; k++) if (r[(rr + k) % NP]) return (rr + k) % NP;
`endif
      return -1;
   endfunction

   logic [TW+WW-1:0] mq[$];
   int               rr_m;
   logic             preq  [NP];
   logic [TW-1:0]    ptag  [NP];
   logic [WW-1:0]    pdata [NP];

   initial begin
      logic [NP-1:0] acks_s;
      int            n0, n1, g;
      logic [WW-1:0] exp_d;
      logic [NP-1:0] r;
      logic [NP-1:0] eacks;
      logic          oack;

      reset = 1'b1;
      drive('0, '0, '0, '0, '0, 1'b0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("reset_oreq", out_if.req, 0);
      check("reset_acks", in_if.acks, 0);
      check("reset_tag", out_if.packet.tag, 0);
      check("reset_data", out_if.packet.data, 0);
      @(posedge clock);
      #1;

      // single packet on plane 1, then backpressure with full/pop interplay on plane 0
      vt.push_back('{2'b10, 0, 0, 3, 32'hDEADBEEF, 1, 2'b10, 0, 0, 0});
      vt.push_back('{2'b00, 0, 0, 0, 0, 1, 2'b00, 1, 3, 32'hDEADBEEF});
      vt.push_back('{2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0});
      vt.push_back('{2'b01, 0, 32'hA0, 0, 0, 0, 2'b01, 0, 0, 0});
      vt.push_back('{2'b01, 1, 32'hA1, 0, 0, 0, 2'b01, 1, 0, 32'hA0});
      vt.push_back('{2'b01, 2, 32'hA2, 0, 0, 0, 2'b00, 1, 0, 32'hA0});
      vt.push_back('{2'b01, 2, 32'hA2, 0, 0, 0, 2'b00, 1, 0, 32'hA0});
      vt.push_back('{2'b01, 2, 32'hA2, 0, 0, 1, 2'b00, 1, 0, 32'hA0});
      vt.push_back('{2'b01, 2, 32'hA2, 0, 0, 0, 2'b01, 1, 1, 32'hA1});
      vt.push_back('{2'b01, 3, 32'hA3, 0, 0, 0, 2'b00, 1, 1, 32'hA1});
      vt.push_back('{2'b01, 3, 32'hA3, 0, 0, 1, 2'b00, 1, 1, 32'hA1});
      vt.push_back('{2'b01, 3, 32'hA3, 0, 0, 1, 2'b01, 1, 2, 32'hA2});
      vt.push_back('{2'b00, 0, 0, 0, 0, 1, 2'b00, 1, 3, 32'hA3});
      vt.push_back('{2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0});

      foreach (vt[i]) begin
         drive(vt[i].reqs, vt[i].t0, vt[i].d0, vt[i].t1, vt[i].d1, vt[i].oack);
         @(negedge clock);
         check($sformatf("vec%0d_acks", i), in_if.acks, vt[i].eacks);
         check($sformatf("vec%0d_oreq", i), out_if.req, vt[i].ereq);
         if (vt[i].ereq) begin
            check($sformatf("vec%0d_tag", i), out_if.packet.tag, vt[i].etag);
            check($sformatf("vec%0d_data", i), out_if.packet.data, vt[i].edata);
         end
         @(posedge clock);
         #1;
      end

      // both planes requesting continuously with the downstream always ready
      do_reset();
      n0 = 0;
      n1 = 0;
      for (int c = 0; c < 10; c++) begin
         drive(2'b11, 0, WW'(32'h10 + n0), 1, WW'(32'h20 + n1), 1'b1);
         @(negedge clock);
         acks_s = in_if.acks;
         check("fair_onehot", 64'($countones(acks_s)), 1);
         if (c > 0) begin
`ifdef TIA_LINK_MERGER_FIXED_PRIORITY_EN
            exp_d = WW'(32'h10 + (c - 1));
`else
            exp_d = ((c - 1) % 2 == 0) ? WW'(32'h10 + (c - 1) / 2) : WW'(32'h20 + (c - 1) / 2);
`endif
            check("fair_oreq", out_if.req, 1);
            check("fair_data", out_if.packet.data, exp_d);
         end
         @(posedge clock);
         #1;
         if (acks_s[0]) n0++;
         if (acks_s[1]) n1++;
      end
      drive(2'b10, 0, 0, 1, WW'(32'h20 + n1), 1'b1);
      @(negedge clock);
      check("fair_p1_after_drop", in_if.acks, 2'b10);
      @(posedge clock);
      #1 drive('0, '0, '0, '0, '0, 1'b1);
      repeat (3) @(posedge clock);
      #1;

      // reset pulsed with two packets buffered
      do_reset();
      drive(2'b01, 7, 32'h77, 0, 0, 1'b0);
      @(posedge clock);
      #1 drive(2'b01, 8, 32'h78, 0, 0, 1'b0);
      @(posedge clock);
      #1 drive('0, '0, '0, '0, '0, 1'b0);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      out_if.ack = 1'b1;
      @(negedge clock);
      check("rst_mid_oreq", out_if.req, 0);
      check("rst_mid_acks", in_if.acks, 0);
      check("rst_mid_data", out_if.packet.data, 0);
      @(posedge clock);
      #1 drive(2'b10, 0, 0, 5, 32'h55, 1'b1);
      @(negedge clock);
      check("rst_post_acks", in_if.acks, 2'b10);
      check("rst_post_oreq0", out_if.req, 0);
      @(posedge clock);
      #1 drive('0, '0, '0, '0, '0, 1'b1);
      @(negedge clock);
      check("rst_post_oreq1", out_if.req, 1);
      check("rst_post_tag", out_if.packet.tag, 5);
      check("rst_post_data", out_if.packet.data, 32'h55);
      @(posedge clock);
      #1;
      @(negedge clock);
      check("rst_post_empty", out_if.req, 0);
      @(posedge clock);
      #1;

      // randomized traffic against the queue model
      do_reset();
      mq.delete();
      rr_m = 0;
      for (int i = 0; i < NP; i++) preq[i] = 1'b0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NP; i++) begin
            if (!preq[i] && $urandom_range(0, 2) != 0) begin
               preq[i]  = 1'b1;
               ptag[i]  = TW'($urandom);
               pdata[i] = $urandom;
            end
         end
         if (c < 300) oack = ($urandom_range(0, 3) != 0);
         else         oack = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < NP; i++) r[i] = preq[i];
         drive(r, ptag[0], pdata[0], ptag[1], pdata[1], oack);
         g     = (mq.size() < DEPTH) ? model_grant(r, rr_m) : -1;
         eacks = '0;
         if (g >= 0) eacks[g] = 1'b1;
         @(negedge clock);
         check("rnd_acks", in_if.acks, eacks);
         check("rnd_oreq", out_if.req, mq.size() != 0);
         if (mq.size() != 0) check("rnd_pkt", {out_if.packet.tag, out_if.packet.data}, mq[0]);
         @(posedge clock);
         if (mq.size() != 0 && oack) void'(mq.pop_front());
         if (g >= 0) begin
            mq.push_back({ptag[g], pdata[g]});
            preq[g] = 1'b0;
            rr_m    = (g + 1) % NP;
         end
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
